// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bundle between the core's data port and dmem_lsu.
//   master (core side): drives req_valid, req_we, req_size, req_unsigned,
//                       req_addr, req_wdata, resp_ready
//   slave  (memory)   : drives req_ready, resp_valid, resp_rdata, resp_err
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: DEPTH x 32-bit little-endian data memory with a load/store unit.
// Byte/half/word stores and signed/unsigned loads, misalignment detection,
// and a configurable read latency behind valid/ready handshakes.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dmem_lsu_if.slave (request and response channels)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | req_ready=1, waiting for a request
// WAIT  | request accepted, latency down-counter running
// RESP  | resp_valid=1, outputs held until resp_ready
module dmem_lsu #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    dmem_lsu_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          unused_addr;
    logic          req_err;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic          sext;
    logic [31:0]   ld_data;
    logic [31:0]   result_d;

    // Result captured at accept, presented only once RESP is entered so the
    // visible outputs stay 0 through WAIT.
    logic [31:0]   pend_rdata_q;
    logic          pend_err_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    // Upper address bits alias; folded here only to mark them intentionally unused.
    assign unused_addr = ^bus.req_addr[31:AW+2];
    assign idx         = bus.req_addr[AW+1:2];
    assign lane        = bus.req_addr[1:0];

    always_comb begin
        req_err  = 1'b0;
        wr_be    = 4'b0000;
        wr_data  = bus.req_wdata;
        rd_word  = mem[idx];
        rd_byte  = rd_word[{lane, 3'b000} +: 8];
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        sext     = ~bus.req_unsigned;
        ld_data  = '0;
        case (bus.req_size)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{bus.req_wdata[7:0]}};
                ld_data = {{24{sext & rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                req_err = lane[0];
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.req_wdata[15:0]}};
                ld_data = {{16{sext & rd_half[15]}}, rd_half};
            end
            2'b10: begin
                req_err = (lane != 2'b00);
                wr_be   = 4'b1111;
                ld_data = rd_word;
            end
            default: req_err = 1'b1;
        endcase
        result_d = (req_err || bus.req_we) ? 32'h0 : ld_data;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_rdata_q <= result_d;
                pend_err_q   <= req_err;
            end
            if (state_q == RESP && state_d == IDLE) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end else if (state_q == IDLE && state_d == RESP) begin
                rdata_q <= result_d;
                err_q   <= req_err;
            end else if (state_q == WAIT && state_d == RESP) begin
                rdata_q <= pend_rdata_q;
                err_q   <= pend_err_q;
            end
        end
    end

    // Array is deliberately not reset; a reset on the accept edge blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && accept && bus.req_we && !req_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) mem[idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Parametrised data memory with a built-in load/store unit for the MIPS core. It supports byte, half and word accesses, signed and unsigned loads, and misalignment detection. The read latency is configurable, and requests and responses use valid/ready handshakes. It replaces the single-cycle word-only data memory on the core's data port, and the core stalls on req_ready/resp_valid.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, ≥4.
LATENCY, 1, cycles from request acceptance to resp_valid; must be ≥1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  out  1  response available.
resp_ready  in  1  consumer takes response.
resp_rdata  out  32  load result, extended; 0 for stores and errors.
resp_err  out  1  misaligned or illegal-size request.

Behaviour:
- Storage: DEPTH x 32 array, little-endian. Byte lane k is bits [8k+7:8k].
- Word index = req_addr[$clog2(DEPTH)+1:2]. Higher address bits are ignored, so addresses alias and wrap modulo 4*DEPTH. Array contents are not reset.
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. The accept edge is any rising edge with req_valid & req_ready & !reset.
  - On accept with LATENCY=1, go to RESP. Otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle; when it reaches 1, the next edge enters RESP.
  - RESP: resp_valid=1, req_ready=0. Outputs hold stable until an edge with resp_ready=1, then return to IDLE.
- Timing: resp_valid is first high exactly LATENCY cycles after the accept edge. Peak throughput is one request per LATENCY+1 cycles, since no request is accepted in the RESP cycle.
- Error check at accept. The request is an error if any of the following holds: size 11; half with addr[0]=1; word with addr[1:0]≠00.
  - An error request does not write memory. It produces resp_err=1 and resp_rdata=0 with normal latency.
- Store, performed at the accept edge:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0];
  - word writes all lanes.
  - Other lanes are unchanged. The response carries resp_rdata=0, resp_err=0.
- Load: the word is sampled at the accept edge and registered.
  - The lane is selected by addr[1:0] (byte) or addr[1] (half).
  - The result is zero-extended if req_unsigned, else sign-extended from bit 7 or bit 15.
  - A word load ignores req_unsigned.
- Inputs are sampled only at the accept edge; changes to req_* during WAIT/RESP have no effect.
- Reset mid-operation: return to IDLE and clear outputs. Any pending response is discarded.
  - A store whose accept edge preceded reset remains written.
  - Reset asserted on a would-be accept edge wins: no accept, no write.
- resp_rdata and resp_err are registered. They are 0 whenever resp_valid=0.

Test Plan:
1. Word store then load, LATENCY=1: store 0xDEADBEEF at 0x10, handshake, load 0x10 → resp_valid exactly 1 cycle after accept, rdata=0xDEADBEEF, err=0.
2. Byte/half lanes: word 0x11223344 at 0x20; sb 0xAA to 0x22 → word reads 0x11AA3344; lb 0x22 → 0xFFFFFFAA; lbu → 0x000000AA; lh 0x22 → 0x000011AA; sh 0x8001 to 0x20, lhu 0x20 → 0x00008001, lh → 0xFFFF8001.
3. Misalignment: sw to 0x21, lh at 0x23, size=11 → each response has err=1, rdata=0; a word re-read of 0x20 confirms memory unchanged.
4. Latency/backpressure, LATENCY=4: load accepted at edge N → resp_valid first at cycle N+4; hold resp_ready=0 for 3 cycles → rdata stable, req_ready=0; req_ready returns 1 the cycle after the resp_ready edge.
5. Aliasing, DEPTH=64: store 0xCAFEF00D at 0x100 → load at 0x000 returns 0xCAFEF00D.
6. Reset mid-op: with LATENCY=3, accept a load, assert reset in WAIT → next cycle resp_valid=0, req_ready=1. A store accepted before that reset reads back its written value afterwards.
